// File: rtl/bin_gray_counter_if.sv
// Counter control and status bundle for bin_gray_counter.
// master drives the controls and observes the count; slave is the counter itself.
interface bin_gray_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin_out;
  logic [WIDTH-1:0] gray_out;
  logic             wrap;
  logic             at_max;
  logic             at_min;

  modport master (
    output en, up_dn, load, load_bin,
    input  bin_out, gray_out, wrap, at_max, at_min
  );

  modport slave (
    input  en, up_dn, load, load_bin,
    output bin_out, gray_out, wrap, at_max, at_min
  );
endinterface

// File: rtl/bin_gray_counter.sv
// Up/down binary counter with a registered Gray-code view of the same count.
// The Gray code is encoded from the next binary value and captured on the same
// edge as the binary count, so bin_out and gray_out are always consistent.
module bin_gray_counter #(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0,
  parameter int WRAP_EN   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  bin_gray_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] RST_BIN  = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_q, gray_q;
  logic             wrap_q, at_max_q, at_min_q;

  logic [WIDTH-1:0] nxt_bin, nxt_gray;
  logic             nxt_wrap;

  // Next count: load beats count beats hold; ends either wrap or saturate.
  always_comb begin
    nxt_bin  = bin_q;
    nxt_wrap = 1'b0;
    if (bus.load) begin
      nxt_bin = bus.load_bin;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (&bin_q) begin
          if (WRAP_EN != 0) begin
            nxt_bin  = '0;
            nxt_wrap = 1'b1;
          end
        end else begin
          nxt_bin = bin_q + ONE;
        end
      end else begin
        if (~|bin_q) begin
          if (WRAP_EN != 0) begin
            nxt_bin  = '1;
            nxt_wrap = 1'b1;
          end
        end else begin
          nxt_bin = bin_q - ONE;
        end
      end
    end
  end

  // Gray encode the next value so it lands in the same flop stage as bin_q.
  genvar i;
  generate
    for (i = 0; i < WIDTH - 1; i++) begin : g_enc
      assign nxt_gray[i] = nxt_bin[i] ^ nxt_bin[i+1];
    end
  endgenerate
  assign nxt_gray[WIDTH-1] = nxt_bin[WIDTH-1];

  // Count, code, wrap pulse and end flags all register together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q    <= RST_BIN;
      gray_q   <= RST_GRAY;
      wrap_q   <= 1'b0;
      at_max_q <= &RST_BIN;
      at_min_q <= ~|RST_BIN;
    end else begin
      bin_q    <= nxt_bin;
      gray_q   <= nxt_gray;
      wrap_q   <= nxt_wrap;
      at_max_q <= &nxt_bin;
      at_min_q <= ~|nxt_bin;
    end
  end

  assign bus.bin_out  = bin_q;
  assign bus.gray_out = gray_q;
  assign bus.wrap     = wrap_q;
  assign bus.at_max   = at_max_q;
  assign bus.at_min   = at_min_q;
endmodule
